adc_frame_packer: RTL and testbench
===================================

Name: adc_frame_packer

Overview:
Downstream of data_acquis_controller. Consumes the 16-bit ADC samples it deserializes from SDATA/SCLK, groups them into fixed-length acquisition frames, and packs them two per 32-bit word behind a tagged header word. Buffers words in a small internal FIFO and drives the write side of the 32-bit Xillybus host FIFO, honouring its full flag. All logic runs on clk_100.

Parameters:
FRAME_LEN, 1024, samples per frame; must be ≥1; odd values allowed
FIFO_DEPTH, 8, internal word FIFO depth; power of two, ≥2
HEADER_TAG, 16'hA5A5, low half of every header word

Ports:
clk_100  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a frame
sample_data  in  16  ADC sample from data_acquis_controller
sample_valid  in  1  sample_data valid this cycle; no backpressure to upstream
fifo_full  in  1  host FIFO full
fifo_din  out  32  word to host FIFO
fifo_wr_en  out  1  host FIFO write strobe
busy  out  1  high while state ≠ IDLE
overflow  out  1  sticky: a word was dropped because the internal FIFO was full
frame_cnt  out  16  number of completed frames, mod 2^16

Behaviour:
- Reset (RST high at a clk_100 edge): state=IDLE, internal FIFO emptied, pair register cleared, sample counter=0, frame_cnt=0, overflow=0. Therefore fifo_wr_en=0, busy=0, and fifo_din=0 while the FIFO is empty. A reset mid-frame discards the partial pair and all buffered words.
- FSM states: IDLE, HDR, COLLECT.
  - IDLE: sample_valid is ignored. If start=1, go to HDR.
  - HDR: one cycle long. Push {frame_cnt, HEADER_TAG}, then go to COLLECT. sample_valid is ignored in this cycle.
  - COLLECT: each cycle with sample_valid=1 accepts one sample and increments the sample counter.
    - Even-indexed sample (0, 2, …): latch into the low-half register.
    - Odd-indexed sample: push {sample_data, low_reg}.
    - The earlier sample always occupies bits [15:0].
  - Frame end: when the accepted sample is number FRAME_LEN:
    - If FRAME_LEN is odd, push {16'h0000, sample_data} in that same cycle.
    - Return to IDLE, clear the sample counter, and increment frame_cnt (0xFFFF wraps to 0x0000).
- start while busy=1 is ignored and is not queued.
- Internal FIFO:
  - First-word-fall-through.
  - A push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set. overflow is cleared only by RST.
  - Dropped words do not stall the sample counter or the FSM, so frame length is preserved in the counting.
- Output side (combinational):
  - fifo_wr_en = !empty && !fifo_full.
  - fifo_din = head word.
  - A pop occurs on each edge where fifo_wr_en=1.
  - Words leave in push order. No write is issued while fifo_full=1.
- Latency: start sampled at edge E0 → HDR during the following cycle → header pushed at E1 → fifo_wr_en=1 in the cycle after E1 (if fifo_full=0). A pair-completing sample accepted at edge Ek appears on fifo_din in the cycle after Ek when the FIFO was otherwise empty.
- Throughput: one word per cycle out. Sustained input of one sample per cycle needs only 0.5 word per cycle.
- Occupancy never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
1. FRAME_LEN=4, fifo_full=0, start, then samples 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles → writes 0x0000A5A5, 0x22221111, 0x44443333 in order. Then frame_cnt=1, busy=0, overflow=0.
2. FRAME_LEN=3, samples 0xAAAA, 0xBBBB, 0xCCCC with gaps of 2 idle cycles → 0x0000A5A5, 0xBBBBAAAA, 0x0000CCCC. A second frame's header is 0x0001A5A5.
3. FIFO_DEPTH=8, FRAME_LEN=4, fifo_full held high for 20 cycles across the frame → fifo_wr_en stays 0. After release, 3 consecutive writes with identical values to scenario 1 and overflow=0.
4. FIFO_DEPTH=8, FRAME_LEN=20, fifo_full high throughout the frame → 11 pushes attempted, overflow=1 after the 9th. After release, exactly 8 writes (header plus the first 7 pairs), and frame_cnt=1.
5. FRAME_LEN=8: pulse start again after 3 samples → ignored, and the frame completes with 5 words total. Then RST after 2 samples of the next frame → same-cycle-after outputs fifo_wr_en=0, busy=0, frame_cnt=0, and the next frame's header is 0x0000A5A5.
6. Push/pop collision: internal FIFO full (8 words), fifo_full drops in the same cycle a pair completes → word accepted, overflow stays 0, all 9 words delivered in order.

Source files
------------

// File: rtl/adc_frame_packer.sv
// adc_frame_packer
//   Groups 16-bit ADC samples into fixed-length frames, packs two samples per
//   32-bit word behind a {frame_cnt, HEADER_TAG} header word, buffers the words
//   in a small first-word-fall-through FIFO and drives the write side of the
//   host FIFO.
// Ports:
//   clk_100      : system clock, rising edge
//   RST          : synchronous active-high reset
//   start        : one-cycle frame request (ignored while busy)
//   sample_data  : ADC sample
//   sample_valid : sample_data valid this cycle (no backpressure)
//   fifo_full    : host FIFO full
//   fifo_din     : head word of the internal FIFO (0 when empty)
//   fifo_wr_en   : host FIFO write strobe (internal FIFO pops on it)
//   busy         : frame in progress
//   overflow     : sticky, a word was dropped because the internal FIFO was full
//   frame_cnt    : completed frames, mod 2^16
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] HEADER_TAG = 16'hA5A5
) (
  input  logic        clk_100,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  input  logic        fifo_full,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    COLLECT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic [15:0]        low_q, low_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [31:0]        mem_d [FIFO_DEPTH];

  logic               push_c;
  logic [31:0]        push_word_c;
  logic               push_ok_c;
  logic               pop_c;
  logic               empty_c;

  // Frame sequencing: header, then samples paired low-half first.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    low_d        = low_q;
    frame_cnt_d  = frame_cnt_q;
    push_c       = 1'b0;
    push_word_c  = 32'h0000_0000;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
        end
      end
      HDR: begin
        push_c      = 1'b1;
        push_word_c = {frame_cnt_q, HEADER_TAG};
        state_d     = COLLECT;
      end
      COLLECT: begin
        if (sample_valid) begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          if (!sample_cnt_q[0]) begin
            low_d = sample_data;
            // A trailing unpaired sample only occurs when FRAME_LEN is odd.
            if (sample_cnt_q == CNT_LAST) begin
              push_c      = 1'b1;
              push_word_c = {16'h0000, sample_data};
            end
          end else begin
            push_c      = 1'b1;
            push_word_c = {sample_data, low_q};
          end
          if (sample_cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            sample_cnt_d = '0;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word FIFO: a push into a full FIFO still lands if the head leaves this cycle.
  always_comb begin
    empty_c    = (occ_q == '0);
    pop_c      = !empty_c && !fifo_full;
    push_ok_c  = push_c && ((occ_q != OCC_FULL) || pop_c);
    overflow_d = overflow_q | (push_c & ~push_ok_c);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_word_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_ok_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state, counters and pointers.
  always_ff @(posedge clk_100) begin
    if (RST) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      low_q        <= '0;
      frame_cnt_q  <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      low_q        <= low_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

  // Storage needs no reset: occupancy gates what is visible.
  always_ff @(posedge clk_100) begin
    mem_q <= mem_d;
  end

  assign fifo_wr_en = pop_c;
  assign fifo_din   = empty_c ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign overflow   = overflow_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer
//   Directed bench: four packers with FRAME_LEN 4, 3, 20 and 8 share stimulus;
//   each scenario resets them and checks the writes of one instance.
module tb_adc_frame_packer;

  logic              clk_100 = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [15:0]       sample_data = 16'h0000;
  logic              sample_valid = 1'b0;
  logic              fifo_full = 1'b0;
  logic [3:0][31:0]  din;
  logic [3:0]        wr;
  logic [3:0]        bsy;
  logic [3:0]        ovf;
  logic [3:0][15:0]  fcnt;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                act = 0;
  logic [31:0]       log_w[$];
  int                log_t[$];

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;

  adc_frame_packer #(.FRAME_LEN(4), .FIFO_DEPTH(8)) u_fl4 (
    .clk_100(clk_100), .RST(rst), .start(start), .sample_data(sample_data),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .fifo_din(din[0]),
    .fifo_wr_en(wr[0]), .busy(bsy[0]), .overflow(ovf[0]), .frame_cnt(fcnt[0]));
  adc_frame_packer #(.FRAME_LEN(3), .FIFO_DEPTH(8)) u_fl3 (
    .clk_100(clk_100), .RST(rst), .start(start), .sample_data(sample_data),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .fifo_din(din[1]),
    .fifo_wr_en(wr[1]), .busy(bsy[1]), .overflow(ovf[1]), .frame_cnt(fcnt[1]));
  adc_frame_packer #(.FRAME_LEN(20), .FIFO_DEPTH(8)) u_fl20 (
    .clk_100(clk_100), .RST(rst), .start(start), .sample_data(sample_data),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .fifo_din(din[2]),
    .fifo_wr_en(wr[2]), .busy(bsy[2]), .overflow(ovf[2]), .frame_cnt(fcnt[2]));
  adc_frame_packer #(.FRAME_LEN(8), .FIFO_DEPTH(8)) u_fl8 (
    .clk_100(clk_100), .RST(rst), .start(start), .sample_data(sample_data),
    .sample_valid(sample_valid), .fifo_full(fifo_full), .fifo_din(din[3]),
    .fifo_wr_en(wr[3]), .busy(bsy[3]), .overflow(ovf[3]), .frame_cnt(fcnt[3]));

  // Record host-FIFO writes of the instance under test, mid-cycle.
  always @(negedge clk_100) begin
    if (wr[act]) begin
      log_w.push_back(din[act]);
      log_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  // start pulse, then the HDR cycle
  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic do_reset(input int inst);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    act = inst;
    log_w.delete();
    log_t.delete();
  endtask

  task automatic chk_log_len(input string tag, input int n);
    chk(tag, 32'(log_w.size()), 32'(n));
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] exp);
    if (idx < log_w.size()) chk(tag, log_w[idx], exp);
    else chk(tag, 32'hDEAD_BEEF, exp);
  endtask

  initial begin
    logic [15:0] s_lo;
    logic [15:0] s_hi;
    fifo_full = 1'b0;
    do_reset(0);

    // Reset state
    chk("rst_wr_en", 32'(wr[0]), 32'd0);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ovf", 32'(ovf[0]), 32'd0);
    chk("rst_fcnt", 32'(fcnt[0]), 32'd0);
    chk("rst_din", din[0], 32'h0);

    // 1: FRAME_LEN=4 back-to-back samples
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s1_busy", 32'(bsy[0]), 32'd1);
    chk("s1_wr_in_hdr", 32'(wr[0]), 32'd0);
    step();
    chk("s1_hdr_wr_en", 32'(wr[0]), 32'd1);
    chk("s1_hdr_din", din[0], 32'h0000_A5A5);
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    send(16'h4444);
    idle(4);
    chk_log_len("s1_nwords", 3);
    chk_word("s1_w0", 0, 32'h0000_A5A5);
    chk_word("s1_w1", 1, 32'h2222_1111);
    chk_word("s1_w2", 2, 32'h4444_3333);
    chk("s1_fcnt", 32'(fcnt[0]), 32'd1);
    chk("s1_busy_end", 32'(bsy[0]), 32'd0);
    chk("s1_ovf", 32'(ovf[0]), 32'd0);

    // 2: FRAME_LEN=3 with gaps, odd tail word, second header
    do_reset(1);
    begin_frame();
    send(16'hAAAA); idle(2);
    send(16'hBBBB); idle(2);
    send(16'hCCCC); idle(3);
    chk_log_len("s2_nwords", 3);
    chk_word("s2_w0", 0, 32'h0000_A5A5);
    chk_word("s2_w1", 1, 32'hBBBB_AAAA);
    chk_word("s2_w2", 2, 32'h0000_CCCC);
    begin_frame();
    send(16'h0001); send(16'h0002); send(16'h0003);
    idle(3);
    chk_word("s2_hdr2", 3, 32'h0001_A5A5);
    chk_word("s2_tail2", 5, 32'h0000_0003);
    chk("s2_fcnt", 32'(fcnt[1]), 32'd2);

    // 3: host full for 20 cycles across a FRAME_LEN=4 frame
    do_reset(0);
    fifo_full = 1'b1;
    begin_frame();
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    idle(14);
    chk("s3_wr_held", 32'(wr[0]), 32'd0);
    chk_log_len("s3_no_writes", 0);
    fifo_full = 1'b0;
    idle(6);
    chk_log_len("s3_nwords", 3);
    chk_word("s3_w0", 0, 32'h0000_A5A5);
    chk_word("s3_w1", 1, 32'h2222_1111);
    chk_word("s3_w2", 2, 32'h4444_3333);
    if (log_t.size() == 3) begin
      chk("s3_consec01", 32'(log_t[1] - log_t[0]), 32'd1);
      chk("s3_consec12", 32'(log_t[2] - log_t[1]), 32'd1);
    end else begin
      chk("s3_consec", 32'(log_t.size()), 32'd3);
    end
    chk("s3_ovf", 32'(ovf[0]), 32'd0);

    // 4: FRAME_LEN=20, host full throughout: 11 pushes, 8 kept
    do_reset(2);
    fifo_full = 1'b1;
    begin_frame();
    for (int i = 1; i <= 20; i++) begin
      send(16'h0100 + 16'(i));
      if (i == 14) chk("s4_ovf_after8", 32'(ovf[2]), 32'd0);
      if (i == 16) chk("s4_ovf_after9", 32'(ovf[2]), 32'd1);
    end
    idle(2);
    fifo_full = 1'b0;
    idle(12);
    chk_log_len("s4_nwords", 8);
    chk_word("s4_hdr", 0, 32'h0000_A5A5);
    for (int k = 1; k <= 7; k++) begin
      s_lo = 16'h0100 + 16'(2 * k - 1);
      s_hi = 16'h0100 + 16'(2 * k);
      chk($sformatf("s4_pair%0d", k), log_w.size() > k ? log_w[k] : 32'hDEAD_BEEF, {s_hi, s_lo});
    end
    chk("s4_fcnt", 32'(fcnt[2]), 32'd1);
    chk("s4_ovf_sticky", 32'(ovf[2]), 32'd1);

    // 5: start while busy ignored; reset mid-frame
    do_reset(3);
    begin_frame();
    send(16'h0011); send(16'h0022); send(16'h0033);
    start = 1'b1;
    step();
    start = 1'b0;
    send(16'h0044); send(16'h0055); send(16'h0066); send(16'h0077); send(16'h0088);
    idle(6);
    chk_log_len("s5_nwords", 5);
    chk_word("s5_w4", 4, 32'h0088_0077);
    chk("s5_busy", 32'(bsy[3]), 32'd0);
    chk("s5_fcnt", 32'(fcnt[3]), 32'd1);
    begin_frame();
    send(16'h0101); send(16'h0202);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s5_rst_wr_en", 32'(wr[3]), 32'd0);
    chk("s5_rst_busy", 32'(bsy[3]), 32'd0);
    chk("s5_rst_fcnt", 32'(fcnt[3]), 32'd0);
    idle(2);
    begin_frame();
    chk("s5_hdr_wr_en", 32'(wr[3]), 32'd1);
    chk("s5_hdr_din", din[3], 32'h0000_A5A5);

    // 6: push into a full FIFO in the same cycle the host frees up
    do_reset(2);
    fifo_full = 1'b1;
    begin_frame();
    for (int i = 1; i <= 15; i++) send(16'h0200 + 16'(i));
    chk("s6_ovf_pre", 32'(ovf[2]), 32'd0);
    fifo_full = 1'b0;
    send(16'h0200 + 16'd16);
    chk("s6_ovf_collide", 32'(ovf[2]), 32'd0);
    for (int i = 17; i <= 20; i++) send(16'h0200 + 16'(i));
    idle(14);
    chk_log_len("s6_nwords", 11);
    chk_word("s6_hdr", 0, 32'h0000_A5A5);
    for (int k = 1; k <= 10; k++) begin
      s_lo = 16'h0200 + 16'(2 * k - 1);
      s_hi = 16'h0200 + 16'(2 * k);
      chk($sformatf("s6_pair%0d", k), log_w.size() > k ? log_w[k] : 32'hDEAD_BEEF, {s_hi, s_lo});
    end
    chk("s6_ovf_end", 32'(ovf[2]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
